imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the CPU's instruction memory. It accepts a framed byte stream on a valid/ready interface, assembles 37-bit instruction words, writes them sequentially into instruction memory from address 0, and verifies a trailing XOR checksum. It holds the CPU in reset until a load completes cleanly, then releases it.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for the boot loader.
// master is the stream source / memory side; slave is the loader.
interface imem_loader_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 37
) ();
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream into 37-bit instruction words,
// writes them from address 0, verifies an XOR checksum, then releases the CPU.
module imem_loader #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 37
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic [1:0]   error
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

  state_t              state, state_n;
  logic [7:0]          cnt_lo;
  logic [7:0]          xsum;
  logic [10:0]         total;
  logic [10:0]         word_cnt;
  logic [2:0]          idx;
  logic [31:0]         word_buf;
  logic [15:0]         hdr_n;
  logic [INSTR_W-1:0]  word_n;
  logic                xfer, load, wr, err_set;
  logic [1:0]          err_n;

  assign bus.byte_ready = (state == HDR0) || (state == HDR1) ||
                          (state == DATA) || (state == CSUM);

  always_comb begin
    xfer    = bus.byte_valid && bus.byte_ready;
    hdr_n   = {bus.byte_data, cnt_lo};
    word_n  = {bus.byte_data[4:0], word_buf};
    load    = 1'b0;
    wr      = 1'b0;
    err_set = 1'b0;
    err_n   = 2'b00;
    state_n = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n = HDR0;
          load    = 1'b1;
        end
      end
      HDR0: if (xfer) state_n = HDR1;
      HDR1: begin
        if (xfer) begin
          if (hdr_n > 16'd1024) begin
            state_n = ERR;
            err_set = 1'b1;
            err_n   = 2'b01;
          end else if (hdr_n == 16'd0) begin
            state_n = CSUM;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (xfer && idx == 3'd4) begin
          if (bus.byte_data[7:5] != '0) begin
            state_n = ERR;
            err_set = 1'b1;
            err_n   = 2'b10;
          end else begin
            wr = 1'b1;
            if (word_cnt + 11'd1 == total) state_n = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          if (bus.byte_data == xsum) begin
            state_n = DONE;
          end else begin
            state_n = ERR;
            err_set = 1'b1;
            err_n   = 2'b11;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cnt_lo         <= '0;
      xsum           <= '0;
      total          <= '0;
      word_cnt       <= '0;
      idx            <= '0;
      word_buf       <= '0;
    end else begin
      state       <= state_n;
      busy        <= (state_n == HDR0) || (state_n == HDR1) ||
                     (state_n == DATA) || (state_n == CSUM);
      done        <= (state_n == DONE);
      cpu_reset   <= (state_n != DONE);
      bus.imem_we <= wr;
      if (load) begin
        xsum          <= '0;
        idx           <= '0;
        word_cnt      <= '0;
        error         <= '0;
        bus.imem_addr <= '0;
      end else begin
        if (bus.imem_we) bus.imem_addr <= bus.imem_addr + ADDR_W'(1);
        if (err_set) error <= err_n;
        if (xfer && state != CSUM) xsum <= xsum ^ bus.byte_data;
        if (xfer && state == HDR0) cnt_lo <= bus.byte_data;
        if (xfer && state == HDR1) total <= hdr_n[10:0];
        if (xfer && state == DATA) begin
          if (idx == 3'd4) begin
            idx <= '0;
          end else begin
            idx      <= idx + 3'd1;
            word_buf <= {bus.byte_data, word_buf[31:8]};
          end
        end
        if (wr) begin
          bus.imem_wdata <= word_n;
          word_cnt       <= word_cnt + 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames
// compared against a frame-level reference model.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic [1:0] error;

  imem_loader_if bus ();

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  logic [63:0] obs_q[$];
  logic        prev_we = 1'b0;
  int unsigned stretch = 0;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_q.push_back((64'(bus.imem_addr) << 37) | 64'(bus.imem_wdata));
      if (prev_we) stretch++;
    end
    prev_we = (bus.imem_we === 1'b1);
  end

  // Reference model: interprets the frame from its byte-level rules.
  logic [7:0]  fr[$];
  logic [63:0] exp_q[$];
  int          exp_consumed;
  logic [1:0]  exp_err;
  logic        exp_done;

  function automatic void model();
    int         n;
    logic [7:0] x;
    logic [36:0] w;
    exp_q.delete();
    exp_done = 1'b0;
    n = int'(fr[0]) + 256 * int'(fr[1]);
    if (n > 1024) begin
      exp_err      = 2'b01;
      exp_consumed = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      int b;
      b = 2 + 5 * k;
      if (fr[b+4] >= 8'd32) begin
        exp_err      = 2'b10;
        exp_consumed = b + 5;
        return;
      end
      w = 37'(fr[b]) + (37'(fr[b+1]) << 8) + (37'(fr[b+2]) << 16) +
          (37'(fr[b+3]) << 24) + (37'(fr[b+4]) << 32);
      exp_q.push_back((64'(k) << 37) | 64'(w));
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 5 * n; i++) x = x ^ fr[i];
    exp_consumed = 3 + 5 * n;
    if (fr[2+5*n] == x) begin
      exp_done = 1'b1;
      exp_err  = 2'b00;
    end else begin
      exp_err  = 2'b11;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    @(negedge clk);
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.byte_ready) begin
      check("ready_timeout", 64'(bus.byte_ready), 64'd1);
      bus.byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic run_frame(input string name, input int max_gap);
    int nw;
    model();
    obs_q.delete();
    stretch = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_cpu_reset_on_start"}, 64'(cpu_reset), 64'd1);
    check({name, "_busy_on_start"}, 64'(busy), 64'd1);
    start = 1'b0;
    for (int i = 0; i < exp_consumed; i++)
      send_byte(fr[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    #1;
    bus.byte_valid = 1'b0;
    check({name, "_error"}, 64'(error), 64'(exp_err));
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_cpu_reset"}, 64'(cpu_reset), 64'(!exp_done));
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    repeat (3) @(negedge clk);
    nw = obs_q.size();
    check({name, "_nwrites"}, 64'(nw), 64'(exp_q.size()));
    for (int i = 0; i < nw && i < exp_q.size(); i++)
      check({name, "_write"}, obs_q[i], exp_q[i]);
    check({name, "_we_one_cycle"}, 64'(stretch), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Asynchronous reset mid-cycle, no clock edge in between.
    #2 reset = 1'b1;
    #1;
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("rst_imem_we", 64'(bus.imem_we), 64'd0);
    check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_byte_ready", 64'(bus.byte_ready), 64'd0);

    fr = '{8'h02, 8'h00, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'h94};
    run_frame("two_word", 0);
    check("two_word_w0", obs_q.size() > 0 ? obs_q[0] : '0, 64'h0123456789);
    check("two_word_w1", obs_q.size() > 1 ? obs_q[1] : '0, (64'd1 << 37) | 64'h1FFFFFFFFF);

    fr[12] = 8'h95;
    run_frame("bad_csum", 0);

    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
    run_frame("pad_bits", 0);

    fr = '{8'h01, 8'h04};
    run_frame("count_1025", 0);

    fr = '{8'h00, 8'h04};
    for (int i = 0; i < 1024 * 5; i++) fr.push_back(8'($urandom_range(31, 0)));
    fr.push_back(8'h00);
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 2 + 1024 * 5; i++) x = x ^ fr[i];
      fr[2+1024*5] = x;
    end
    run_frame("count_1024", 0);

    fr = '{8'h00, 8'h00, 8'h00};
    run_frame("count_zero", 0);

    fr = '{8'h02, 8'h00, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'h94};
    run_frame("two_word_gaps", 5);

    // Reload from DONE, then reset after three payload bytes.
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("reload_cpu_reset", 64'(cpu_reset), 64'd1);
    check("reload_done", 64'(done), 64'd0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(fr[i], 0);
    #3 reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("midrst_imem_we", 64'(bus.imem_we), 64'd0);
    check("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_writes", 64'(obs_q.size()), 64'd0);
    check("midrst_idle_ready", 64'(bus.byte_ready), 64'd0);

    // Random frames.
    for (int it = 0; it < 25; it++) begin
      fr.delete();
      if ($urandom_range(7, 0) == 0) begin
        n = int'($urandom_range(65535, 1025));
        fr.push_back(8'(n));
        fr.push_back(8'(n >> 8));
      end else begin
        logic [7:0] x;
        int         bad;
        n   = int'($urandom_range(6, 0));
        bad = ($urandom_range(7, 0) == 0) ? int'($urandom_range(n, 0)) : -1;
        fr.push_back(8'(n));
        fr.push_back(8'h00);
        for (int k = 0; k < n; k++) begin
          for (int j = 0; j < 4; j++) fr.push_back(8'($urandom));
          if (k == bad) fr.push_back(8'($urandom_range(255, 32)));
          else          fr.push_back(8'($urandom_range(31, 0)));
        end
        x = 8'h00;
        foreach (fr[i]) x = x ^ fr[i];
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        fr.push_back(x);
      end
      run_frame("rand", 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
